// File: rtl/thunderbird_seq.sv
// Parametrised tail-light sequencer: thermometer turn sequences per side,
// hazard mode, a tick prescaler so each step lasts TICK_DIV clocks, a
// trailing dark gap, and a combinational brake overlay.
module thunderbird_seq #(
    parameter int unsigned LAMPS    = 3,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] L,
    output logic [LAMPS-1:0] R,
    output logic             busy
);

    localparam int unsigned KW = $clog2(LAMPS + 1);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);
    localparam logic [KW-1:0] KMax   = KW'(LAMPS);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLeft  = 3'd1,
        StRight = 3'd2,
        StHaz   = 3'd3,
        StGap   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [LAMPS-1:0] l_pat_q, l_pat_d;
    logic [LAMPS-1:0] r_pat_q, r_pat_d;
    // Sides that brake may force on: everything not currently sequenced.
    logic             force_l_q, force_l_d;
    logic             force_r_q, force_r_d;
    logic             busy_q, busy_d;
    logic             tick;

    // Thermometer pattern with the lowest k lamps lit.
    function automatic logic [LAMPS-1:0] therm(input logic [KW-1:0] k);
        logic [LAMPS-1:0] t;
        for (int i = 0; i < LAMPS; i++) begin
            t[i] = (KW'(i) < k);
        end
        return t;
    endfunction

    assign tick = (pre_q == PreMax);

    // Next state, step counter and prescaler, plus next registered lamp decode.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pre_d   = '0;
        unique case (state_q)
            StIdle: begin
                k_d = '0;
                if (hazard || (left && right)) begin
                    state_d = StHaz;
                    k_d     = KW'(1);
                end else if (left) begin
                    state_d = StLeft;
                    k_d     = KW'(1);
                end else if (right) begin
                    state_d = StRight;
                    k_d     = KW'(1);
                end
            end
            StLeft, StRight, StHaz: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    if (k_q == KMax) begin
                        state_d = StGap;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StGap: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                k_d   = '0;
                if (tick) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                k_d     = '0;
            end
        endcase

        l_pat_d   = ((state_d == StLeft) || (state_d == StHaz)) ? therm(k_d) : '0;
        r_pat_d   = ((state_d == StRight) || (state_d == StHaz)) ? therm(k_d) : '0;
        force_l_d = (state_d == StIdle) || (state_d == StGap) || (state_d == StRight);
        force_r_d = (state_d == StIdle) || (state_d == StGap) || (state_d == StLeft);
        busy_d    = (state_d != StIdle);
    end

    // Sequencer state and registered Moore outputs; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            k_q       <= '0;
            pre_q     <= '0;
            l_pat_q   <= '0;
            r_pat_q   <= '0;
            force_l_q <= 1'b1;
            force_r_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pre_q     <= pre_d;
            l_pat_q   <= l_pat_d;
            r_pat_q   <= r_pat_d;
            force_l_q <= force_l_d;
            force_r_q <= force_r_d;
            busy_q    <= busy_d;
        end
    end

    assign L    = l_pat_q | {LAMPS{brake & force_l_q}};
    assign R    = r_pat_q | {LAMPS{brake & force_r_q}};
    assign busy = busy_q;

endmodule

// File: tb/tb_thunderbird_seq.sv
// Bench for thunderbird_seq: a directed vector table on a LAMPS=3/TICK_DIV=2
// instance, a hand sequence on a LAMPS=5/TICK_DIV=1 instance, then random
// stimulus on both checked against an elapsed-time reference model.
module tb_thunderbird_seq;

    logic       clk = 1'b0;
    logic       reset, left, right, hazard, brake;
    logic [2:0] l1, r1;
    logic [4:0] l2, r2;
    logic       busy1, busy2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    thunderbird_seq #(.LAMPS(3), .TICK_DIV(2)) u_dut1 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .L(l1), .R(r1), .busy(busy1)
    );

    thunderbird_seq #(.LAMPS(5), .TICK_DIV(1)) u_dut2 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .L(l2), .R(r2), .busy(busy2)
    );

    typedef struct {
        bit       rst, l, r, h, b;
        bit [2:0] el, er;
        bit       eb;
    } vec_t;

    vec_t tbl[$];

    // Reference model: active flag, request kind (0 left, 1 right, 2 hazard)
    // and cycles elapsed since the sequence was entered.
    int lamps_of[2] = '{3, 5};
    int div_of[2]   = '{2, 1};
    bit m_act[2];
    int m_kind[2];
    int m_e[2];

    task automatic add(input bit rst, l, r, h, b, input bit [2:0] el, er, input bit eb);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.h = h; v.b = b;
        v.el = el; v.er = er; v.eb = eb;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit rst, l, r, h, b);
        reset = rst; left = l; right = r; hazard = h; brake = b;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    task automatic upd(input int i);
        if (reset) begin
            m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
            if (hazard || (left && right)) begin
                m_act[i] = 1'b1; m_kind[i] = 2; m_e[i] = 0;
            end else if (left) begin
                m_act[i] = 1'b1; m_kind[i] = 0; m_e[i] = 0;
            end else if (right) begin
                m_act[i] = 1'b1; m_kind[i] = 1; m_e[i] = 0;
            end
        end else begin
            m_e[i]++;
            if (m_e[i] == (lamps_of[i] + 1) * div_of[i]) m_act[i] = 1'b0;
        end
    endtask

    function automatic logic [7:0] exp_side(input int i, input bit is_left);
        int   step;
        int   n;
        bit   lit;
        bit   gap;
        logic [7:0] ones;
        logic [7:0] pat;
        ones = 8'((1 << lamps_of[i]) - 1);
        if (!m_act[i]) return brake ? ones : 8'h00;
        step = m_e[i] / div_of[i];
        gap  = (step >= lamps_of[i]);
        n    = gap ? 0 : step + 1;
        pat  = 8'((1 << n) - 1);
        lit  = (m_kind[i] == 2) || (is_left ? (m_kind[i] == 0) : (m_kind[i] == 1));
        if (gap) return brake ? ones : 8'h00;
        if (lit) return pat;
        return (brake && m_kind[i] != 2) ? ones : 8'h00;
    endfunction

    task automatic cycle();
        @(posedge clk);
        upd(0);
        upd(1);
        #1;
    endtask

    initial begin
        // Scenario 1/2: reset with left held, then left sequence and gap.
        add(1,1,0,0,0, 0,0,0); add(1,1,0,0,0, 0,0,0); add(0,1,0,0,0, 0,0,0);
        add(0,0,0,0,0, 1,0,1); add(0,0,0,0,0, 1,0,1); add(0,0,0,0,0, 3,0,1);
        add(0,0,0,0,0, 3,0,1); add(0,0,0,0,0, 7,0,1); add(0,0,0,0,0, 7,0,1);
        add(0,0,0,0,0, 0,0,1); add(0,0,0,0,0, 0,0,1);
        // Scenario 3: left+right, then hazard alone, identical traces.
        for (int p = 0; p < 2; p++) begin
            add(0, p == 0, p == 0, p == 1, 0, 0,0,0);
            add(0,0,0,0,0, 1,1,1); add(0,0,0,0,0, 1,1,1); add(0,0,0,0,0, 3,3,1);
            add(0,0,0,0,0, 3,3,1); add(0,0,0,0,0, 7,7,1); add(0,0,0,0,0, 7,7,1);
            add(0,0,0,0,0, 0,0,1); add(0,0,0,0,0, 0,0,1);
        end
        // Scenario 4: brake in IDLE, during LEFT at k=2, in GAP, during HAZ.
        add(0,0,0,0,1, 7,7,0); add(0,1,0,0,1, 7,7,0);
        add(0,0,0,0,0, 1,0,1); add(0,0,0,0,0, 1,0,1); add(0,0,0,0,1, 3,7,1);
        add(0,0,0,0,1, 3,7,1); add(0,0,0,0,0, 7,0,1); add(0,0,0,0,0, 7,0,1);
        add(0,0,0,0,1, 7,7,1); add(0,0,0,0,0, 0,0,1);
        add(0,0,0,1,0, 0,0,0);
        add(0,0,0,0,1, 1,1,1); add(0,0,0,0,1, 1,1,1); add(0,0,0,0,0, 3,3,1);
        add(0,0,0,0,1, 3,3,1); add(0,0,0,0,1, 7,7,1); add(0,0,0,0,0, 7,7,1);
        add(0,0,0,0,0, 0,0,1); add(0,0,0,0,0, 0,0,1);
        // Scenario 5: right during LEFT ignored; held left restarts after 1 idle.
        add(0,1,0,0,0, 0,0,0);
        add(0,0,1,0,0, 1,0,1); add(0,0,0,0,0, 1,0,1); add(0,0,0,0,0, 3,0,1);
        add(0,0,0,0,0, 3,0,1); add(0,0,0,0,0, 7,0,1); add(0,0,0,0,0, 7,0,1);
        add(0,0,0,0,0, 0,0,1); add(0,0,0,0,0, 0,0,1);
        add(0,1,0,0,0, 0,0,0);
        add(0,1,0,0,0, 1,0,1); add(0,1,0,0,0, 1,0,1); add(0,1,0,0,0, 3,0,1);
        add(0,1,0,0,0, 3,0,1); add(0,1,0,0,0, 7,0,1); add(0,1,0,0,0, 7,0,1);
        add(0,1,0,0,0, 0,0,1); add(0,1,0,0,0, 0,0,1); add(0,1,0,0,0, 0,0,0);
        // Scenario 6a: reset while L=011.
        add(0,0,0,0,0, 1,0,1); add(0,0,0,0,0, 1,0,1); add(1,0,0,0,0, 3,0,1);
        add(0,0,0,0,0, 0,0,0); add(0,0,0,0,0, 0,0,0);

        drive(1, 0, 0, 0, 0);
        #1;
        cycle();

        foreach (tbl[j]) begin
            drive(tbl[j].rst, tbl[j].l, tbl[j].r, tbl[j].h, tbl[j].b);
            @(negedge clk);
            chk($sformatf("tbl%0d.L", j), 8'(l1), 8'(tbl[j].el));
            chk($sformatf("tbl%0d.R", j), 8'(r1), 8'(tbl[j].er));
            chk($sformatf("tbl%0d.busy", j), 8'(busy1), 8'(tbl[j].eb));
            cycle();
        end

        // Scenario 6b: LAMPS=5, TICK_DIV=1 left pulse.
        begin
            logic [4:0] seq6[7];
            seq6 = '{5'h01, 5'h03, 5'h07, 5'h0f, 5'h1f, 5'h00, 5'h00};
            drive(0, 1, 0, 0, 0);
            @(negedge clk);
            chk("l5.idle_busy", 8'(busy2), 8'h00);
            cycle();
            drive(0, 0, 0, 0, 0);
            for (int s = 0; s < 7; s++) begin
                @(negedge clk);
                chk($sformatf("l5.L%0d", s), 8'(l2), 8'(seq6[s]));
                chk($sformatf("l5.R%0d", s), 8'(r2), 8'h00);
                chk($sformatf("l5.busy%0d", s), 8'(busy2), (s < 6) ? 8'h01 : 8'h00);
                cycle();
            end
        end

        // Random stimulus against the reference model on both instances.
        drive(1, 0, 0, 0, 0);
        cycle();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0);
            @(negedge clk);
            chk("rnd3.L", 8'(l1), exp_side(0, 1'b1));
            chk("rnd3.R", 8'(r1), exp_side(0, 1'b0));
            chk("rnd3.busy", 8'(busy1), 8'(m_act[0]));
            chk("rnd5.L", 8'(l2), exp_side(1, 1'b1));
            chk("rnd5.R", 8'(r2), exp_side(1, 1'b0));
            chk("rnd5.busy", 8'(busy2), 8'(m_act[1]));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/thunderbird_seq.md
Name: thunderbird_seq

Overview:
- Parametrised tail-light sequencer; successor to the fixed 3-lamp turn-signal FSM.
- Drives LAMPS lamps per side with thermometer turn sequences and a hazard mode.
- Adds a tick prescaler, so each step lasts TICK_DIV clocks, plus a brake overlay and a busy flag.
- Sits between the debounced switch inputs and the lamp drivers.

Parameters:
LAMPS, 3, lamps per side; legal range 2..8
TICK_DIV, 4, clocks per sequence step; legal value >=1; prescaler width clog2(TICK_DIV), minimum 1 bit

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
left  in  1  left turn request, level-sampled
right  in  1  right turn request, level-sampled
hazard  in  1  hazard request, level-sampled
brake  in  1  brake pedal, combinational overlay
L  out  LAMPS  left lamps; bit 0 innermost
R  out  LAMPS  right lamps; bit 0 innermost
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (sampled on clk edge): state=IDLE, step k=0, prescaler=0. With brake=0: L=R=0, busy=0. Reset overrides all inputs, including mid-sequence.
- States: IDLE, LEFT, RIGHT, HAZ, GAP.
- IDLE request sampling, in priority order:
  - (hazard | (left & right)) -> HAZ
  - else left -> LEFT
  - else right -> RIGHT
  - else stay IDLE
  - On entry to any sequence: k=1, prescaler=0.
- Prescaler: counts only outside IDLE; wraps at TICK_DIV-1. tick = (prescaler==TICK_DIV-1). With TICK_DIV=1, tick is high every cycle.
- LEFT/RIGHT/HAZ: on tick, if k<LAMPS then k<=k+1; if k==LAMPS then go to GAP, k=0.
- GAP: lamps dark for exactly TICK_DIV cycles (one tick), then IDLE.
- Total busy time per request: (LAMPS+1)*TICK_DIV cycles. IDLE then lasts at least 1 cycle before a held request re-enters.
- Request inputs (left, right, hazard) are ignored outside IDLE. Sequences always run to completion; only reset aborts.
- Moore decode, with thermometer pattern T(k) = (1<<k)-1:
  - LEFT: L=T(k), R=0
  - RIGHT: R=T(k), L=0
  - HAZ: L=R=T(k)
  - GAP and IDLE: L=R=0
- Brake overlay (combinational from brake, zero latency):
  - In IDLE, GAP, LEFT and RIGHT, any side not being sequenced is forced all-ones.
  - The sequenced side keeps its pattern.
  - In IDLE and GAP both sides are all-ones.
  - In HAZ brake has no effect.
- busy is a registered-state decode with no input dependence.
- k width is clog2(LAMPS+1). Unreachable state encodings recover to IDLE on the next edge.

Test Plan:
All scenarios use LAMPS=3, TICK_DIV=2 unless stated.
1. reset=1 for 2 cycles with left=1 -> L=R=000, busy=0 throughout. First edge after release enters LEFT -> L=001.
2. left pulsed 1 cycle in IDLE -> L: 001,001,011,011,111,111,000,000 (GAP, busy=1), then busy=0. R=000 throughout. Total busy = 8 cycles.
3. left=right=1 together in IDLE -> HAZ: L=R stepping 001,011,111 (2 cycles each), then 000 for 2 cycles. hazard=1 alone gives the identical trace.
4. brake=1 in IDLE -> L=R=111 in the same cycle. brake=1 during LEFT at k=2 -> L=011, R=111. brake=1 during HAZ -> no change to the HAZ pattern.
5. right pulsed while LEFT at k=1 -> no effect; LEFT completes unchanged. left held continuously -> sequence restarts after exactly 1 IDLE cycle.
6. reset asserted while L=011 -> next cycle L=000, busy=0. Repeat scenario 2 with LAMPS=5, TICK_DIV=1 -> L: 00001,00011,00111,01111,11111,00000, then IDLE.
